str_chan_arb: RTL and testbench
===============================

STR_CHAN_ARB -- requirements
Module: str_chan_arb

Interface -- parameters
REQ-001 SHALL have parameter DW, default 24, sample width in bits.
REQ-002 SHALL have parameter NCH, default 4, number of input channels (2..8).
REQ-003 SHALL have parameter FRAME_LOCK, default 1: 1 = hold grant until tlast beat, 0 = re-arbitrate every beat.

Interface -- ports
REQ-004 SHALL have port clk, input, 1, single clock for all logic.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port ch_en, input, NCH, per-channel enable.
REQ-007 SHALL have port s_axis_tdata, input, NCH*DW, channel c at bits [c*DW +: DW].
REQ-008 SHALL have port s_axis_tvalid, input, NCH, per-channel valid.
REQ-009 SHALL have port s_axis_tlast, input, NCH, per-channel end-of-frame.
REQ-010 SHALL have port s_axis_tready, output, NCH, per-channel ready.
REQ-011 SHALL have port m_axis_tdata, output, DW, arbitrated sample.
REQ-012 SHALL have port m_axis_tvalid, output, 1, output valid.
REQ-013 SHALL have port m_axis_tready, input, 1, downstream ready.
REQ-014 SHALL have port m_axis_tlast, output, 1, copied from the source beat.
REQ-015 SHALL have port m_axis_tid, output, $clog2(NCH), source channel index of the output beat.

Function
REQ-016 SHALL treat a channel as eligible only when ch_en[c] && s_axis_tvalid[c].
REQ-017 SHALL use round-robin priority: search starts at (last granted + 1) mod NCH; after reset last granted = NCH-1, so channel 0 has priority.
REQ-018 SHALL register the output in one stage: input beat accepted on cycle N appears on m_axis_* on cycle N+1.
REQ-019 SHALL accept an input beat when the output register is empty or m_axis_tready=1, so back-to-back beats run at 1 beat/clk with no bubbles.
REQ-020 SHALL assert s_axis_tready[c] only for the currently granted channel, and only when the output register can load; all other bits SHALL be 0.
REQ-021 SHALL hold m_axis_tdata/tlast/tid stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-022 SHALL, with FRAME_LOCK=1, use FSM states IDLE and LOCKED: IDLE->LOCKED on an accepted beat with tlast=0; LOCKED->IDLE on an accepted beat with tlast=1; an accepted tlast=1 beat taken from IDLE stays in IDLE.
REQ-023 SHALL, in LOCKED, serve only the locked channel, even if its ch_en drops; the frame SHALL complete to tlast.
REQ-024 SHALL, in LOCKED with the locked channel's tvalid=0, stall: no other channel is served and no output beat is generated.
REQ-025 SHALL, with FRAME_LOCK=0, re-arbitrate on every accepted beat; the FSM stays in IDLE.
REQ-026 SHALL update the round-robin pointer only on an accepted beat that ends a grant (every beat when FRAME_LOCK=0; tlast beat when FRAME_LOCK=1).
REQ-027 SHALL drive no grant and no ready when no channel is eligible; m_axis_tvalid SHALL fall after the pending beat drains.

Reset
REQ-028 SHALL, on rst_n=0, asynchronously clear m_axis_tvalid, m_axis_tlast, m_axis_tdata and m_axis_tid to 0, set the FSM to IDLE and set last granted to NCH-1.
REQ-029 SHALL, on reset asserted mid-frame, discard the partial frame; no resumption after reset.

Structure
REQ-030 SHALL place the arb_state_t enum (IDLE, LOCKED) and the NCH bounds constants in the shared package str_pkg.
REQ-031 SHALL implement the round-robin search in one combinational sub-module rr_pick (inputs: request vector, pointer; outputs: one-hot grant, index, any).

Verification
REQ-032 SHALL cover: FRAME_LOCK=0, all 4 channels valid, m_ready=1 -> tid sequence 0,1,2,3,0... with one beat per clk.
REQ-033 SHALL cover: FRAME_LOCK=1, ch0 and ch2 each sending 3-beat frames -> output ch0 x3 (tlast on the 3rd), then ch2 x3, with no interleave.
REQ-034 SHALL cover: m_axis_tready low for 5 cycles with data 0x123456 pending -> output held constant and all s_axis_tready = 0.
REQ-035 SHALL cover: ch_en[1] cleared after beat 1 of a 4-beat frame on ch1 -> remaining 3 beats delivered, then ch1 never granted again.
REQ-036 SHALL cover: rst_n pulsed low mid-frame -> m_axis_tvalid=0 immediately (asynchronous); first grant after release goes to channel 0.
REQ-037 SHALL cover: locked channel's tvalid drops for 4 cycles while ch3 is valid -> no ch3 beat is output until the locked frame's tlast.

Source files
------------

// File: rtl/str_pkg.sv
// Shared definitions for the streaming channel arbiter.
//   arb_state_t : frame-lock FSM states
//   NCH_MIN/MAX : legal range of the channel-count parameter
package str_pkg;

  localparam int NCH_MIN = 2;
  localparam int NCH_MAX = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req   : request vector, one bit per channel
//   ptr   : index where the search starts (highest priority this cycle)
//   grant : one-hot grant of the first requester found from ptr upward (wrapping)
//   idx   : binary index of the granted channel
//   any   : at least one request present
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  // NOTE: combinational logic uses blocking assignments, and every output is
  // given a default before the loop so no path can leave it unassigned (latch).
  always_comb begin
    int c;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    c     = 0;
    for (int i = 0; i < N; i++) begin
      c = (int'(ptr) + i) % N;
      if (!any && req[c]) begin
        any      = 1'b1;
        idx      = IW'(c);
        grant[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/str_chan_arb.sv
// Round-robin arbiter merging NCH AXI-Stream channels into one, with an
// optional frame lock that keeps a channel granted until its tlast beat.
//   clk, rst_n     : clock, asynchronous active-low reset
//   ch_en          : per-channel enable (only checked when choosing a new channel)
//   s_axis_*       : NCH input streams, channel c data at [c*DW +: DW]
//   m_axis_*       : single registered output stream, tid = source channel
module str_chan_arb
  import str_pkg::*;
#(
  parameter  int DW         = 24,
  parameter  int NCH        = 4,
  parameter  int FRAME_LOCK = 1,
  localparam int IW         = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    ch_en,
  input  logic [NCH*DW-1:0] s_axis_tdata,
  input  logic [NCH-1:0]    s_axis_tvalid,
  input  logic [NCH-1:0]    s_axis_tlast,
  output logic [NCH-1:0]    s_axis_tready,
  output logic [DW-1:0]     m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic [IW-1:0]     m_axis_tid
);

  if (NCH < NCH_MIN || NCH > NCH_MAX) begin : g_bad_nch
    $error("str_chan_arb: NCH out of supported range");
  end

  arb_state_t     state;
  logic [IW-1:0]  last_grant;
  logic [IW-1:0]  lock_ch;
  logic [IW-1:0]  ptr;
  logic [NCH-1:0] eligible;
  logic [NCH-1:0] pick_oh;
  logic [IW-1:0]  pick_idx;
  logic           pick_any;
  logic [IW-1:0]  sel_idx;
  logic           sel_valid;
  logic           sel_last;
  logic [DW-1:0]  sel_data;
  logic           load_ok;
  logic           accept;

  assign eligible = ch_en & s_axis_tvalid;

  // Search starts one past the channel that last finished a grant.
  assign ptr = (last_grant == IW'(NCH - 1)) ? '0 : last_grant + IW'(1);

  rr_pick #(.N(NCH)) u_rr_pick (
    .req   (eligible),
    .ptr   (ptr),
    .grant (pick_oh),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // While locked, only the locked channel is served and its enable is ignored
  // so that a frame already started always completes.
  always_comb begin
    sel_idx   = pick_idx;
    sel_valid = pick_any;
    if (state == LOCKED) begin
      sel_idx   = lock_ch;
      sel_valid = s_axis_tvalid[lock_ch];
    end
  end

  // The output register can take a new beat when empty or being drained.
  assign load_ok  = !m_axis_tvalid || m_axis_tready;
  assign accept   = sel_valid && load_ok;
  assign sel_data = s_axis_tdata[int'(sel_idx)*DW +: DW];
  assign sel_last = s_axis_tlast[sel_idx];

  always_comb begin
    s_axis_tready = '0;
    if (accept) s_axis_tready[sel_idx] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      lock_ch       <= '0;
      last_grant    <= IW'(NCH - 1);
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tid    <= '0;
    end else begin
      // Output stage: load on accept, otherwise empty once drained. Data,
      // tlast and tid only change on a load, so they hold under back-pressure.
      if (accept) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= sel_data;
        m_axis_tlast  <= sel_last;
        m_axis_tid    <= sel_idx;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end

      if (FRAME_LOCK != 0 && accept) begin
        if (state == IDLE) begin
          if (!sel_last) begin
            state   <= LOCKED;
            lock_ch <= sel_idx;
          end
        end else if (sel_last) begin
          state <= IDLE;
        end
      end

      // Pointer moves only when a grant ends: each beat, or each frame end.
      if (accept && (FRAME_LOCK == 0 || sel_last)) last_grant <= sel_idx;
    end
  end

endmodule

// File: tb/tb_str_chan_arb.sv
// Scoreboard bench for str_chan_arb. Instance 0 is built with FRAME_LOCK=0,
// instance 1 with FRAME_LOCK=1. Per-channel source queues feed the inputs;
// expected output beats are queued when stimulus is issued and a monitor pops
// and compares them on every output handshake.
module tb_str_chan_arb;

  localparam int DW  = 24;
  localparam int NCH = 4;
  localparam int IW  = 2;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic [IW-1:0] tid;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NCH-1:0]    ch_en    [2];
  logic [NCH-1:0]    pause    [2];
  logic [NCH*DW-1:0] s_tdata  [2];
  logic [NCH-1:0]    s_tvalid [2];
  logic [NCH-1:0]    s_tlast  [2];
  logic [NCH-1:0]    s_tready [2];
  logic [DW-1:0]     m_tdata  [2];
  logic              m_tvalid [2];
  logic              m_tready [2];
  logic              m_tlast  [2];
  logic [IW-1:0]     m_tid    [2];
  logic [NCH-1:0]    hs       [2];

  beat_t src_q [2*NCH][$];
  exp_t  exp_q [2][$];
  exp_t  mon_e;

  int n_checks  = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int first_cyc = -1;
  int last_cyc  = -1;
  int n_beats0  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  str_chan_arb #(.DW(DW), .NCH(NCH), .FRAME_LOCK(0)) dut_fl0 (
    .clk           (clk),
    .rst_n         (rst_n),
    .ch_en         (ch_en[0]),
    .s_axis_tdata  (s_tdata[0]),
    .s_axis_tvalid (s_tvalid[0]),
    .s_axis_tlast  (s_tlast[0]),
    .s_axis_tready (s_tready[0]),
    .m_axis_tdata  (m_tdata[0]),
    .m_axis_tvalid (m_tvalid[0]),
    .m_axis_tready (m_tready[0]),
    .m_axis_tlast  (m_tlast[0]),
    .m_axis_tid    (m_tid[0])
  );

  str_chan_arb #(.DW(DW), .NCH(NCH), .FRAME_LOCK(1)) dut_fl1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .ch_en         (ch_en[1]),
    .s_axis_tdata  (s_tdata[1]),
    .s_axis_tvalid (s_tvalid[1]),
    .s_axis_tlast  (s_tlast[1]),
    .s_axis_tready (s_tready[1]),
    .m_axis_tdata  (m_tdata[1]),
    .m_axis_tvalid (m_tvalid[1]),
    .m_axis_tready (m_tready[1]),
    .m_axis_tlast  (m_tlast[1]),
    .m_axis_tid    (m_tid[1])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_beat(input int d, input int c, input logic [DW-1:0] data, input logic last);
    beat_t b;
    b.data = data;
    b.last = last;
    src_q[d*NCH+c].push_back(b);
  endtask

  task automatic expect_beat(input int d, input int c, input logic [DW-1:0] data, input logic last);
    exp_t e;
    e.data = data;
    e.last = last;
    e.tid  = IW'(c);
    exp_q[d].push_back(e);
  endtask

  task automatic wait_drain(input int d, input int budget);
    int n = 0;
    while (exp_q[d].size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check($sformatf("d%0d drain (beats left)", d), exp_q[d].size(), 0);
  endtask

  task automatic wait_src(input int d, input int c, input int sz, input int budget);
    int n = 0;
    while (src_q[d*NCH+c].size() != sz && n < budget) begin
      tick();
      n++;
    end
    check($sformatf("d%0d ch%0d source depth", d, c), src_q[d*NCH+c].size(), sz);
  endtask

  task automatic wait_valid(input int d, input int budget);
    int n = 0;
    while (!m_tvalid[d] && n < budget) begin
      tick();
      n++;
    end
    check($sformatf("d%0d output valid arrives", d), m_tvalid[d], 1);
  endtask

  // Source driver: pops a beat after its handshake and presents the next head.
  initial begin
    for (int d = 0; d < 2; d++) begin
      s_tvalid[d] = '0;
      s_tlast[d]  = '0;
      s_tdata[d]  = '0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) hs[d] = s_tvalid[d] & s_tready[d];
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < NCH; c++) begin
          if (hs[d][c] && rst_n && src_q[d*NCH+c].size() != 0) void'(src_q[d*NCH+c].pop_front());
          if (src_q[d*NCH+c].size() != 0 && !pause[d][c]) begin
            s_tvalid[d][c]            = 1'b1;
            s_tdata[d][c*DW +: DW]    = src_q[d*NCH+c][0].data;
            s_tlast[d][c]             = src_q[d*NCH+c][0].last;
          end else begin
            s_tvalid[d][c] = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: every output handshake is compared against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rst_n && m_tvalid[d] && m_tready[d]) begin
          if (exp_q[d].size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL d%0d unexpected beat: got tid=%0d data=0x%0h, expected none", d, m_tid[d], m_tdata[d]);
          end else begin
            mon_e = exp_q[d].pop_front();
            check($sformatf("d%0d beat {tid,last,data}", d),
                  {m_tid[d], m_tlast[d], m_tdata[d]}, {mon_e.tid, mon_e.last, mon_e.data});
          end
          if (d == 0) begin
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            n_beats0++;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      ch_en[d]    = '1;
      pause[d]    = '0;
      m_tready[d] = 1'b1;
    end

    // Reset state
    #3;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d reset tvalid", d), m_tvalid[d], 0);
      check($sformatf("d%0d reset tdata", d), m_tdata[d], 0);
      check($sformatf("d%0d reset tid/tlast", d), {m_tid[d], m_tlast[d]}, 0);
      check($sformatf("d%0d reset s_tready", d), s_tready[d], 0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    tick();

    // FRAME_LOCK=0: all four channels valid -> 0,1,2,3,0,1,2,3 back to back
    for (int c = 0; c < NCH; c++) begin
      push_beat(0, c, {4'h1, 4'(c), 16'h0000}, 1'b0);
      push_beat(0, c, {4'h1, 4'(c), 16'h0001}, 1'b1);
    end
    for (int b = 0; b < 2; b++)
      for (int c = 0; c < NCH; c++)
        expect_beat(0, c, {4'h1, 4'(c), 16'(b)}, b == 1);
    wait_drain(0, 40);
    check("d0 beat count", n_beats0, 8);
    check("d0 no bubbles (cycle span)", last_cyc - first_cyc, 7);

    // FRAME_LOCK=1: ch0 and ch2 3-beat frames, no interleave
    for (int b = 0; b < 3; b++) begin
      push_beat(1, 0, 24'hA00000 + 24'(b), b == 2);
      push_beat(1, 2, 24'hA20000 + 24'(b), b == 2);
    end
    for (int b = 0; b < 3; b++) expect_beat(1, 0, 24'hA00000 + 24'(b), b == 2);
    for (int b = 0; b < 3; b++) expect_beat(1, 2, 24'hA20000 + 24'(b), b == 2);
    wait_drain(1, 40);

    // Back-pressure: 0x123456 from ch3 (pointer now at 3) held for 5 cycles
    m_tready[1] = 1'b0;
    push_beat(1, 3, 24'h123456, 1'b1);
    push_beat(1, 0, 24'h0A0001, 1'b1);
    expect_beat(1, 3, 24'h123456, 1'b1);
    expect_beat(1, 0, 24'h0A0001, 1'b1);
    wait_valid(1, 20);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold tdata", m_tdata[1], 24'h123456);
      check("hold tid/tlast/tvalid", {m_tid[1], m_tlast[1], m_tvalid[1]}, {2'd3, 1'b1, 1'b1});
      check("hold s_tready", s_tready[1], 0);
    end
    tick();
    m_tready[1] = 1'b1;
    wait_drain(1, 20);

    // ch_en[1] cleared after beat 1 of a 4-beat ch1 frame
    for (int b = 0; b < 4; b++) begin
      push_beat(1, 1, 24'hB10000 + 24'(b), b == 3);
      expect_beat(1, 1, 24'hB10000 + 24'(b), b == 3);
    end
    wait_src(1, 1, 3, 20);
    ch_en[1][1] = 1'b0;
    push_beat(1, 2, 24'hB20000, 1'b1);
    expect_beat(1, 2, 24'hB20000, 1'b1);
    push_beat(1, 1, 24'hB1F000, 1'b0);
    push_beat(1, 1, 24'hB1F001, 1'b1);
    wait_drain(1, 40);
    repeat (6) tick();
    check("disabled ch1 frame untouched", src_q[1*NCH+1].size(), 2);
    src_q[1*NCH+1].delete();
    repeat (2) tick();
    ch_en[1][1] = 1'b1;

    // Locked ch0 stalls 4 cycles while ch3 waits
    for (int b = 0; b < 3; b++) begin
      push_beat(1, 0, 24'hC00000 + 24'(b), b == 2);
      expect_beat(1, 0, 24'hC00000 + 24'(b), b == 2);
    end
    wait_src(1, 0, 2, 20);
    pause[1][0] = 1'b1;
    push_beat(1, 3, 24'hC30000, 1'b1);
    expect_beat(1, 3, 24'hC30000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("locked stall ch3 ready", s_tready[1][3], 0);
    end
    tick();
    pause[1][0] = 1'b0;
    wait_drain(1, 40);

    // Asynchronous reset mid-frame, then channel 0 wins first
    m_tready[1] = 1'b0;
    for (int b = 0; b < 4; b++) push_beat(1, 2, 24'hD20000 + 24'(b), b == 3);
    wait_valid(1, 20);
    @(negedge clk);
    #1;
    check("pending before reset", m_tvalid[1], 1);
    rst_n = 1'b0;
    #1;
    check("async reset tvalid", m_tvalid[1], 0);
    check("async reset tdata/tid", {m_tid[1], m_tdata[1]}, 0);
    src_q[1*NCH+2].delete();
    m_tready[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    push_beat(1, 3, 24'hE30000, 1'b1);
    push_beat(1, 1, 24'hE10000, 1'b1);
    push_beat(1, 0, 24'hE00000, 1'b1);
    expect_beat(1, 0, 24'hE00000, 1'b1);
    expect_beat(1, 1, 24'hE10000, 1'b1);
    expect_beat(1, 3, 24'hE30000, 1'b1);
    wait_drain(1, 30);
    wait_drain(0, 5);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
